// File: rtl/btc_blk_minmax_replay_if.sv
// Handshake bundle for the min/max replay stage.
// The collect side and the replay side share one interface.
interface btc_blk_minmax_replay_if;
  logic        inValid;
  logic        inReady;
  logic [63:0] inPix;
  logic        flush;
  logic        outValid;
  logic        outReady;
  logic [63:0] outPix;
  logic [31:0] outMinMax;
  logic        outLast;

  modport master (
    output inValid, inPix, flush, outReady,
    input  inReady, outValid, outPix, outMinMax, outLast
  );

  modport slave (
    input  inValid, inPix, flush, outReady,
    output inReady, outValid, outPix, outMinMax, outLast
  );
endinterface

// File: rtl/btc_blk_minmax_replay.sv
// Buffers one 4x4 RGB555 block, tracks min/max pixel by luma key, then replays
// each beat paired with the block {Min,Max} word for the index encoder.
module btc_blk_minmax_replay #(
  parameter int NBEATS = 4,
  parameter int CNTW   = 3
) (
  input logic                     clock,
  input logic                     reset,
  btc_blk_minmax_replay_if.slave  bus
);
  typedef enum logic {COLLECT, REPLAY} stateT;

  localparam logic [CNTW-1:0] LASTIDX = CNTW'(NBEATS - 1);

  stateT            stateReg, stateNext;
  logic [CNTW-1:0]  cntReg, cntNext;
  logic [15:0]      minReg, maxReg;
  logic [7:0]       minKeyReg, maxKeyReg;
  logic [63:0]      outPixReg;
  logic [31:0]      outMinMaxReg;
  logic             outLastReg;
  logic [63:0]      bufMem [NBEATS];

  logic             accept, advance, atLast;
  logic [CNTW-1:0]  readAddr;
  logic [15:0]      lanePix [4];
  logic [7:0]       laneKey [4];
  logic [15:0]      minMerged, maxMerged;
  logic [7:0]       minKeyMerged, maxKeyMerged;

  // Bit 15 is deliberately left out of the key but kept in the stored pixel.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : gLane
      assign lanePix[gi] = bus.inPix[16*gi +: 16];
      assign laneKey[gi] = {lanePix[gi][9], lanePix[gi][8], lanePix[gi][14], lanePix[gi][4],
                            lanePix[gi][7], lanePix[gi][13], lanePix[gi][3], lanePix[gi][6]};
    end
  endgenerate

  // Lanes are merged in ascending order with strict compares, so earlier pixels win ties.
  always_comb begin
    minMerged    = (cntReg == '0) ? lanePix[0] : minReg;
    maxMerged    = (cntReg == '0) ? lanePix[0] : maxReg;
    minKeyMerged = (cntReg == '0) ? laneKey[0] : minKeyReg;
    maxKeyMerged = (cntReg == '0) ? laneKey[0] : maxKeyReg;
    for (int i = 0; i < 4; i++) begin
      if (laneKey[i] < minKeyMerged) begin
        minMerged    = lanePix[i];
        minKeyMerged = laneKey[i];
      end
      if (laneKey[i] > maxKeyMerged) begin
        maxMerged    = lanePix[i];
        maxKeyMerged = laneKey[i];
      end
    end
  end

  always_comb begin
    stateNext = stateReg;
    cntNext   = cntReg;
    accept    = 1'b0;
    advance   = 1'b0;
    atLast    = (cntReg == LASTIDX);
    if (bus.flush) begin
      stateNext = COLLECT;
      cntNext   = '0;
    end else begin
      case (stateReg)
        COLLECT: begin
          if (bus.inValid) begin
            accept = 1'b1;
            if (atLast) begin
              cntNext   = '0;
              stateNext = REPLAY;
            end else begin
              cntNext = cntReg + 1'b1;
            end
          end
        end
        REPLAY: begin
          if (bus.outReady) begin
            advance = 1'b1;
            if (atLast) begin
              cntNext   = '0;
              stateNext = COLLECT;
            end else begin
              cntNext = cntReg + 1'b1;
            end
          end
        end
        default: stateNext = COLLECT;
      endcase
    end
  end

  // The first replay beat is fetched on the final accept, giving one-cycle latency.
  assign readAddr = (stateReg == COLLECT) ? '0 : cntReg + 1'b1;

  always_ff @(posedge clock) begin
    if (accept) begin
      bufMem[cntReg] <= bus.inPix;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stateReg     <= COLLECT;
      cntReg       <= '0;
      minReg       <= '0;
      maxReg       <= '0;
      minKeyReg    <= '0;
      maxKeyReg    <= '0;
      outPixReg    <= '0;
      outMinMaxReg <= '0;
      outLastReg   <= 1'b0;
    end else begin
      stateReg <= stateNext;
      cntReg   <= cntNext;
      if (bus.flush) begin
        outLastReg <= 1'b0;
      end else if (accept) begin
        minReg    <= minMerged;
        maxReg    <= maxMerged;
        minKeyReg <= minKeyMerged;
        maxKeyReg <= maxKeyMerged;
        if (atLast) begin
          outMinMaxReg <= {minMerged, maxMerged};
          outPixReg    <= bufMem[readAddr];
          outLastReg   <= 1'b0;
        end
      end else if (advance) begin
        if (atLast) begin
          outLastReg <= 1'b0;
        end else begin
          outPixReg  <= bufMem[readAddr];
          outLastReg <= (readAddr == LASTIDX);
        end
      end
    end
  end

  assign bus.inReady   = (stateReg == COLLECT);
  assign bus.outValid  = (stateReg == REPLAY);
  assign bus.outPix    = outPixReg;
  assign bus.outMinMax = outMinMaxReg;
  assign bus.outLast   = outLastReg;
endmodule

// File: tb/tb_btc_blk_minmax_replay.sv
// Directed plus randomized checks of btc_blk_minmax_replay against a
// pixel-list reference model of block min/max selection.
module tb_btc_blk_minmax_replay;
  logic clock;
  logic reset;
  int   tests;
  int   fails;

  logic [63:0] blk [4];
  logic [63:0] allBeats [12];

  btc_blk_minmax_replay_if bus ();

  btc_blk_minmax_replay #(.NBEATS(4), .CNTW(3)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [7:0] keyOf(input logic [15:0] v);
    return {v[9], v[8], v[14], v[4], v[7], v[13], v[3], v[6]};
  endfunction

  // Flatten the block into pixel order, find extreme keys, return first pixel holding each.
  function automatic logic [31:0] refMinMax(input logic [63:0] b0, b1, b2, b3);
    logic [63:0] bs [4];
    logic [15:0] pix [$];
    logic [7:0]  minK, maxK;
    logic [15:0] minP, maxP;
    bit          gotMin, gotMax;
    bs = '{b0, b1, b2, b3};
    for (int b = 0; b < 4; b++)
      for (int l = 0; l < 4; l++)
        pix.push_back(bs[b][16*l +: 16]);
    minK = 8'hFF; maxK = 8'h00;
    foreach (pix[i]) begin
      if (keyOf(pix[i]) < minK) minK = keyOf(pix[i]);
      if (keyOf(pix[i]) > maxK) maxK = keyOf(pix[i]);
    end
    gotMin = 0; gotMax = 0; minP = '0; maxP = '0;
    foreach (pix[i]) begin
      if (!gotMin && keyOf(pix[i]) == minK) begin minP = pix[i]; gotMin = 1; end
      if (!gotMax && keyOf(pix[i]) == maxK) begin maxP = pix[i]; gotMax = 1; end
    end
    return {minP, maxP};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] rand64();
    return {$urandom, $urandom};
  endfunction

  task automatic pushBlock();
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      check("collect_ready", 64'(bus.inReady), 64'd1);
      check("collect_no_valid", 64'(bus.outValid), 64'd0);
      bus.inValid = 1'b1;
      bus.inPix   = blk[i];
    end
    @(negedge clock);
    bus.inValid = 1'b0;
    check("latency_valid", 64'(bus.outValid), 64'd1);
    $display("[TB] block collected mm_ref=%h", refMinMax(blk[0], blk[1], blk[2], blk[3]));
  endtask

  task automatic checkBeat(input int i, input logic [31:0] mm);
    check("replay_valid", 64'(bus.outValid), 64'd1);
    check("replay_pix", bus.outPix, blk[i]);
    check("replay_minmax", 64'(bus.outMinMax), 64'(mm));
    check("replay_last", 64'(bus.outLast), 64'(i == 3));
    check("replay_no_ready", 64'(bus.inReady), 64'd0);
  endtask

  task automatic drainBlock(input int stallAt, input int stallLen);
    logic [31:0] mm;
    mm = refMinMax(blk[0], blk[1], blk[2], blk[3]);
    for (int i = 0; i < 4; i++) begin
      checkBeat(i, mm);
      if (i == stallAt) begin
        bus.outReady = 1'b0;
        repeat (stallLen) begin
          @(negedge clock);
          checkBeat(i, mm);
        end
        bus.outReady = 1'b1;
      end
      @(negedge clock);
    end
    check("drain_no_valid", 64'(bus.outValid), 64'd0);
    check("drain_ready", 64'(bus.inReady), 64'd1);
    $display("[TB] block replayed stall_at=%0d mm=%h", stallAt, mm);
  endtask

  initial begin
    int p, q;
    logic [31:0] mm;
    logic [31:0] refs [3];
    tests = 0; fails = 0;
    reset = 1'b0;
    bus.inValid = 1'b0; bus.inPix = '0; bus.flush = 1'b0; bus.outReady = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("rst_ready", 64'(bus.inReady), 64'd1);
    check("rst_valid", 64'(bus.outValid), 64'd0);
    check("rst_last", 64'(bus.outLast), 64'd0);
    check("rst_pix", bus.outPix, 64'd0);
    check("rst_minmax", 64'(bus.outMinMax), 64'd0);

    // Directed min/max example
    blk = '{64'h0000_7FFF_1234_4210, 64'h1111_2222_3333_4444,
            64'h5555_6666_0421_7BDE, 64'h0C63_18C6_2529_318C};
    pushBlock();
    check("example_minmax", 64'(bus.outMinMax), 64'h0000_7FFF);
    drainBlock(-1, 0);

    // Ties: every key is zero, first occurrence must be kept
    for (int b = 0; b < 4; b++)
      for (int l = 0; l < 4; l++)
        blk[b][16*l +: 16] = ($urandom_range(0, 1) != 0) ? 16'h8000 : 16'h0000;
    blk[0][15:0] = 16'h8000;
    pushBlock();
    check("tie_minmax", 64'(bus.outMinMax), 64'h8000_8000);
    drainBlock(-1, 0);

    // Randomized blocks with backpressure mid-replay
    for (int k = 0; k < 3; k++) begin
      for (int b = 0; b < 4; b++) blk[b] = rand64();
      pushBlock();
      drainBlock(k == 0 ? 2 : int'($urandom_range(0, 3)), 5);
    end

    // Flush after two collected beats; the beat offered alongside flush is dropped
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      bus.inValid = 1'b1;
      bus.inPix   = 64'h7FFF_7FFF_7FFF_7FFF;
    end
    @(negedge clock);
    bus.flush = 1'b1;
    @(negedge clock);
    bus.flush = 1'b0;
    bus.inValid = 1'b0;
    check("flush_a_ready", 64'(bus.inReady), 64'd1);
    check("flush_a_no_valid", 64'(bus.outValid), 64'd0);
    for (int b = 0; b < 4; b++) blk[b] = 64'h3DEF_3DEF_3DEF_3DEF;
    begin
      int pos;
      pos = int'($urandom_range(0, 15));
      blk[pos / 4][16*(pos % 4) +: 16] = 16'h0000;
    end
    pushBlock();
    check("flush_a_minmax", 64'(bus.outMinMax), 64'h0000_3DEF);
    drainBlock(-1, 0);

    // Flush on replay beat 1
    for (int b = 0; b < 4; b++) blk[b] = rand64();
    pushBlock();
    mm = refMinMax(blk[0], blk[1], blk[2], blk[3]);
    checkBeat(0, mm);
    @(negedge clock);
    checkBeat(1, mm);
    bus.flush = 1'b1;
    @(negedge clock);
    bus.flush = 1'b0;
    check("flush_b_no_valid", 64'(bus.outValid), 64'd0);
    check("flush_b_ready", 64'(bus.inReady), 64'd1);
    check("flush_b_last", 64'(bus.outLast), 64'd0);
    for (int b = 0; b < 4; b++) blk[b] = rand64();
    pushBlock();
    drainBlock(-1, 0);

    // Asynchronous reset between edges during replay, on the last beat
    for (int b = 0; b < 4; b++) blk[b] = rand64();
    pushBlock();
    repeat (3) @(negedge clock);
    #2 reset = 1'b0;
    #1;
    check("arst_valid", 64'(bus.outValid), 64'd0);
    check("arst_last", 64'(bus.outLast), 64'd0);
    check("arst_minmax", 64'(bus.outMinMax), 64'd0);
    check("arst_pix", bus.outPix, 64'd0);
    check("arst_ready", 64'(bus.inReady), 64'd1);
    @(negedge clock);
    #2 reset = 1'b1;
    for (int b = 0; b < 4; b++) blk[b] = rand64();
    pushBlock();
    drainBlock(1, 2);

    // Back-to-back blocks with inValid held high: 8 cycles per block
    for (int i = 0; i < 12; i++) allBeats[i] = rand64();
    for (int k = 0; k < 3; k++)
      refs[k] = refMinMax(allBeats[4*k], allBeats[4*k+1], allBeats[4*k+2], allBeats[4*k+3]);
    @(negedge clock);
    p = 0; q = 0;
    for (int c = 0; c < 24; c++) begin
      check("b2b_ready", 64'(bus.inReady), 64'((c % 8) < 4));
      if (bus.outValid) begin
        if (q < 12) begin
          check("b2b_pix", bus.outPix, allBeats[q]);
          check("b2b_minmax", 64'(bus.outMinMax), 64'(refs[q / 4]));
          check("b2b_last", 64'(bus.outLast), 64'((q % 4) == 3));
          if ((q % 4) == 3) $display("[TB] b2b block %0d replayed mm=%h", q / 4, refs[q / 4]);
        end else begin
          check("b2b_extra_valid", 64'(bus.outValid), 64'd0);
        end
        q++;
      end
      if (p < 12) begin
        bus.inValid = 1'b1;
        bus.inPix   = allBeats[p];
        if (bus.inReady) p++;
      end else begin
        bus.inValid = 1'b0;
      end
      @(negedge clock);
    end
    bus.inValid = 1'b0;
    check("b2b_out_count", 64'(q), 64'd12);
    check("b2b_in_count", 64'(p), 64'd12);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
